serial_subtractor: RTL

Bit-serial two's-complement subtractor computing D = A − B one bit per clock, LSB first. It uses a single full-adder cell with a registered carry: the difference bit is A[i] XOR NOT B[i] XOR carry, with the carry preset to 1. It sits alongside the combinational adder cells in the lab datapath and provides the subtraction direction with borrow, zero and signed-overflow flags. It uses a START/DONE handshake so a controller can sequence several operations.

---
 rtl/serial_subtractor_if.sv | 14 +
 rtl/serial_subtractor.sv | 99 +++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: START/DONE handshake, operands and flagged result of the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] D;
    logic             Bo;
    logic             Z;
    logic             V;
    logic             BUSY;
    logic             DONE;
    modport master (output START, A, B, input D, Bo, Z, V, BUSY, DONE);
    modport slave  (input START, A, B, output D, Bo, Z, V, BUSY, DONE);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B, LSB first, one full-adder cell with carry preset to 1
// Result registers D/Bo/Z/V load only on the FIN-entry edge and hold otherwise.
module serial_subtractor #(parameter int WIDTH = 8) (
    input logic CLK,
    input logic RST_N,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sd_q, sd_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, am_q, am_d, bm_q, bm_d;
    logic             bo_q, bo_d, z_q, z_d, v_q, v_d;
    logic             s, cy, nb;
    logic [WIDTH-1:0] sd_nx;
    always_comb begin
        nb      = ~sb_q[0];
        s       = sa_q[0] ^ nb ^ c_q;
        cy      = (sa_q[0] & nb) | (sa_q[0] & c_q) | (nb & c_q);
        sd_nx   = {s, sd_q[WIDTH-1:1]};
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sd_d    = sd_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        am_d    = am_q;
        bm_d    = bm_q;
        d_d     = d_q;
        bo_d    = bo_q;
        z_d     = z_q;
        v_d     = v_q;
        case (state_q)
            IDLE: if (bus.START) begin
                sa_d    = bus.A;
                sb_d    = bus.B;
                am_d    = bus.A[WIDTH-1];
                bm_d    = bus.B[WIDTH-1];
                c_d     = 1'b1;
                cnt_d   = '0;
                sd_d    = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                c_d   = cy;
                sd_d  = sd_nx;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIN;
                    d_d     = sd_nx;
                    bo_d    = ~cy;
                    z_d     = (sd_nx == '0);
                    // s is the result MSB on this last bit
                    v_d     = (am_q != bm_q) & (s != am_q);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
            d_q     <= '0;
            bo_q    <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sd_q    <= sd_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            am_q    <= am_d;
            bm_q    <= bm_d;
            d_q     <= d_d;
            bo_q    <= bo_d;
            z_q     <= z_d;
            v_q     <= v_d;
        end
    end
    assign bus.D    = d_q;
    assign bus.Bo   = bo_q;
    assign bus.Z    = z_q;
    assign bus.V    = v_q;
    assign bus.BUSY = (state_q == SHIFT);
    assign bus.DONE = (state_q == FIN);
endmodule
